// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point adder/subtractor:
// guard/round/sticky width, rounding-mode encoding, and the result flag bundle.
package fp_pkg;

  localparam int GRS_W = 3;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1
  } round_mode_e;

  localparam round_mode_e ROUND_MODE = RNE;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inexact;
  } fp_flags_t;

  // Increment decision for the kept significand given its lsb and the GRS bits.
  function automatic logic round_inc(input round_mode_e mode, input logic lsb,
                                     input logic g, input logic r, input logic s);
    case (mode)
      RNE:     return g & (r | s | lsb);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: number of zero bits above the most significant one;
// an all-zero input returns W.
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din_i,
  output logic [CW-1:0] count_o
);

  always_comb begin
    count_o = CW'(W);
    // Ascending scan: the last hit is the highest set bit.
    for (int i = 0; i < W; i++) begin
      if (din_i[i]) count_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub_pipe.sv
// Three-stage floating-point add/subtract (align, add, normalise/round) with a
// single global stall, flush-to-zero inputs and round-to-nearest-even.
module fp_add_sub_pipe
  import fp_pkg::*;
#(
  parameter int M     = 23,
  parameter int E     = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic             a_sign,
  input  logic [E-1:0]     a_exp,
  input  logic [M-1:0]     a_mant,
  input  logic             b_sign,
  input  logic [E-1:0]     b_exp,
  input  logic [M-1:0]     b_mant,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             c_sign,
  output logic [E-1:0]     c_exp,
  output logic [M-1:0]     c_mant,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_ovf,
  output logic             flag_unf,
  output logic             flag_inexact
);

  localparam int SIGW = M + 1;             // hidden bit + mantissa
  localparam int KW   = SIGW + GRS_W - 1;  // bits kept by the aligner (sticky added after)
  localparam int NW   = SIGW + GRS_W;      // aligned operand width
  localparam int SW   = NW + 1;            // sum with carry-out
  localparam int CW   = $clog2(NW + 1);
  localparam int XW   = E + 2;             // exponent with headroom and sign

  typedef struct packed {
    logic             x_sign;
    logic             y_sign;
    logic [E-1:0]     exp;
    logic [NW-1:0]    x_al;
    logic [NW-1:0]    y_al;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             zero_sign;
    logic [E-1:0]     exp;
    logic [SW-1:0]    sum;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic             sign;
    logic [E-1:0]     exp;
    logic [M-1:0]     mant;
    fp_flags_t        flags;
    logic [TAG_W-1:0] tag;
  } s3_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  logic s1_valid_q, s2_valid_q, s3_valid_q;
  logic advance;

  assign advance  = out_ready | ~s3_valid_q;
  assign in_ready = advance;

  // ---------------- S1: swap by magnitude and align ----------------
  logic [SIGW-1:0] a_sig, b_sig, x_sig, y_sig;
  logic [E-1:0]    x_exp, y_exp, exp_diff;
  logic            b_eff_sign, x_sign, y_sign;
  logic [2*KW-1:0] wide;
  logic [NW-1:0]   y_al;

  // NOTE: every variable gets a value on every path so no latch is inferred.
  always_comb begin
    a_sig      = (a_exp != '0) ? {1'b1, a_mant} : '0;
    b_sig      = (b_exp != '0) ? {1'b1, b_mant} : '0;
    b_eff_sign = b_sign ^ op_sub;
    if ({a_exp, a_sig} >= {b_exp, b_sig}) begin
      x_sign = a_sign;     y_sign = b_eff_sign;
      x_exp  = a_exp;      y_exp  = b_exp;
      x_sig  = a_sig;      y_sig  = b_sig;
    end else begin
      x_sign = b_eff_sign; y_sign = a_sign;
      x_exp  = b_exp;      y_exp  = a_exp;
      x_sig  = b_sig;      y_sig  = a_sig;
    end
    exp_diff = x_exp - y_exp;
    // The low half of the wide vector catches every bit shifted past round.
    wide = {y_sig, {(GRS_W-1){1'b0}}, {KW{1'b0}}} >> exp_diff;
    if (32'(exp_diff) >= 32'(KW)) y_al = {{KW{1'b0}}, |y_sig};
    else                          y_al = {wide[2*KW-1:KW], |wide[KW-1:0]};

    s1_d.x_sign = x_sign;
    s1_d.y_sign = y_sign;
    s1_d.exp    = x_exp;
    s1_d.x_al   = {x_sig, {GRS_W{1'b0}}};
    s1_d.y_al   = y_al;
    s1_d.tag    = in_tag;
  end

  // ---------------- S2: magnitude add or subtract ----------------
  always_comb begin
    s2_d.sign      = s1_q.x_sign;
    s2_d.zero_sign = s1_q.x_sign & s1_q.y_sign;
    s2_d.exp       = s1_q.exp;
    s2_d.tag       = s1_q.tag;
    if (s1_q.x_sign == s1_q.y_sign) s2_d.sum = {1'b0, s1_q.x_al} + {1'b0, s1_q.y_al};
    else                            s2_d.sum = {1'b0, s1_q.x_al} - {1'b0, s1_q.y_al};
  end

  // ---------------- S3: normalise, round, classify ----------------
  logic [CW-1:0] lz;
  logic [NW-1:0] norm;
  logic [XW-1:0] exp_n, exp_r;
  logic [M-1:0]  frac;
  logic          inc, rnd_carry, sum_zero, ovf, unf, inexact;

  fp_lzc #(.W(NW), .CW(CW)) u_lzc (
    .din_i   (s2_q.sum[NW-1:0]),
    .count_o (lz)
  );

  always_comb begin
    sum_zero = (s2_q.sum == '0);
    if (s2_q.sum[SW-1]) begin
      norm  = {s2_q.sum[SW-1:2], s2_q.sum[1] | s2_q.sum[0]};
      exp_n = {2'b00, s2_q.exp} + XW'(1);
    end else begin
      norm  = s2_q.sum[NW-1:0] << lz;
      exp_n = {2'b00, s2_q.exp} - XW'(lz);
    end

    inexact   = |norm[GRS_W-1:0];
    inc       = round_inc(ROUND_MODE, norm[GRS_W], norm[GRS_W-1], norm[GRS_W-2], norm[0]);
    // An all-ones significand that rounds up wraps the fraction to zero.
    rnd_carry = inc & (&norm[NW-1:GRS_W]);
    frac      = norm[NW-2:GRS_W] + M'(inc);
    exp_r     = rnd_carry ? exp_n + XW'(1) : exp_n;

    ovf = ~exp_r[XW-1] & (exp_r >= XW'((2**E) - 1));
    unf = exp_r[XW-1] | (exp_r == '0);

    s3_d               = '0;
    s3_d.tag           = s2_q.tag;
    s3_d.sign          = s2_q.sign;
    s3_d.flags.inexact = inexact;
    if (sum_zero) begin
      s3_d.sign          = s2_q.zero_sign;
      s3_d.flags.inexact = 1'b0;
    end else if (ovf) begin
      s3_d.exp       = '1;
      s3_d.flags.ovf = 1'b1;
    end else if (unf) begin
      s3_d.flags.unf = 1'b1;
    end else begin
      s3_d.exp  = exp_r[E-1:0];
      s3_d.mant = frac;
    end
  end

  // ---------------- Stage registers ----------------
  // NOTE: data registers are reset as well so outputs and tag read 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
    end else if (advance) begin
      // NOTE: non-blocking so each stage captures its predecessor's pre-edge value.
      s1_valid_q <= in_valid;
      s2_valid_q <= s1_valid_q;
      s3_valid_q <= s2_valid_q;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
    end
  end

  assign out_valid    = s3_valid_q;
  assign c_sign       = s3_q.sign;
  assign c_exp        = s3_q.exp;
  assign c_mant       = s3_q.mant;
  assign out_tag      = s3_q.tag;
  assign flag_ovf     = s3_q.flags.ovf;
  assign flag_unf     = s3_q.flags.unf;
  assign flag_inexact = s3_q.flags.inexact;

endmodule

// File: tb/tb_fp_add_sub_pipe.sv
// Directed bench for fp_add_sub_pipe (M=23, E=8): arithmetic vectors, rounding,
// overflow/underflow, zero handling, streaming with stall, and mid-flight reset.
module tb_fp_add_sub_pipe;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic        op_sub = 1'b0;
  logic        a_sign = 1'b0, b_sign = 1'b0;
  logic [7:0]  a_exp = '0, b_exp = '0;
  logic [22:0] a_mant = '0, b_mant = '0;
  logic [3:0]  in_tag = '0, out_tag;
  logic        out_valid, out_ready = 1'b0;
  logic        c_sign;
  logic [7:0]  c_exp;
  logic [22:0] c_mant;
  logic        flag_ovf, flag_unf, flag_inexact;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_add_sub_pipe #(.M(23), .E(8), .TAG_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op_sub       (op_sub),
    .a_sign       (a_sign),
    .a_exp        (a_exp),
    .a_mant       (a_mant),
    .b_sign       (b_sign),
    .b_exp        (b_exp),
    .b_mant       (b_mant),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .c_sign       (c_sign),
    .c_exp        (c_exp),
    .c_mant       (c_mant),
    .out_tag      (out_tag),
    .flag_ovf     (flag_ovf),
    .flag_unf     (flag_unf),
    .flag_inexact (flag_inexact)
  );

  // Operands are written as {sign, exp, mant}; result is {sign, exp, mant, ovf, unf, inexact}.
  // Called at a negedge with the pipeline empty; returns at a negedge with it empty again.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic [3:0] tag, output logic [34:0] res,
                       output logic [3:0] otag, output int lat);
    {a_sign, a_exp, a_mant} = a;
    {b_sign, b_exp, b_mant} = b;
    op_sub    = sub;
    in_tag    = tag;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
    res  = {c_sign, c_exp, c_mant, flag_ovf, flag_unf, flag_inexact};
    otag = out_tag;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if ({c_sign, c_exp, c_mant, flag_ovf, flag_unf, flag_inexact, out_tag} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {c_sign, c_exp, c_mant, flag_ovf, flag_unf, flag_inexact, out_tag});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_add_basic();
    logic [34:0] res;
    logic [3:0]  otag;
    int          lat;
    apply(32'h3F800000, 32'h3F800000, 1'b0, 4'h5, res, otag, lat);
    checks++;
    if (res !== {32'h40000000, 3'b000}) begin
      errors++; $display("FAIL add_one_one: got %h expected %h", res, {32'h40000000, 3'b000});
    end
    checks++;
    if (lat != 3) begin
      errors++; $display("FAIL latency: got %0d expected 3", lat);
    end
    checks++;
    if (otag !== 4'h5) begin
      errors++; $display("FAIL tag_pass: got %h expected 5", otag);
    end
  endtask

  task automatic test_sub();
    logic [31:0] va[3]  = '{32'h3F800000, 32'h3FC00000, 32'h3F800000};
    logic [31:0] vb[3]  = '{32'h3F800000, 32'hBF800000, 32'h40000000};
    logic        vs[3]  = '{1'b1, 1'b0, 1'b1};
    logic [34:0] ve[3]  = '{{32'h00000000, 3'b000}, {32'h3F000000, 3'b000},
                            {32'hBF800000, 3'b000}};
    logic [34:0] res;
    logic [3:0]  otag;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      apply(va[i], vb[i], vs[i], 4'(i + 1), res, otag, lat);
      checks++;
      if ({res, otag} !== {ve[i], 4'(i + 1)} || lat != 3) begin
        errors++;
        $display("FAIL sub_vec%0d: got %h tag %h lat %0d expected %h tag %h lat 3",
                 i, res, otag, lat, ve[i], 4'(i + 1));
      end
    end
  endtask

  task automatic test_round();
    logic [31:0] vb[2] = '{32'h33800000, 32'h33800001};
    logic [34:0] ve[2] = '{{32'h3F800000, 3'b001}, {32'h3F800001, 3'b001}};
    logic [34:0] res;
    logic [3:0]  otag;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      apply(32'h3F800000, vb[i], 1'b0, 4'(i + 6), res, otag, lat);
      checks++;
      if ({res, otag} !== {ve[i], 4'(i + 6)} || lat != 3) begin
        errors++;
        $display("FAIL round_vec%0d: got %h tag %h lat %0d expected %h", i, res, otag, lat, ve[i]);
      end
    end
  endtask

  task automatic test_ovf_unf();
    logic [31:0] va[2] = '{32'h7F7FFFFF, 32'h00800001};
    logic [31:0] vb[2] = '{32'h7F7FFFFF, 32'h80800000};
    logic [34:0] ve[2] = '{{32'h7F800000, 3'b100}, {32'h00000000, 3'b010}};
    logic [34:0] res;
    logic [3:0]  otag;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      apply(va[i], vb[i], 1'b0, 4'(i + 10), res, otag, lat);
      checks++;
      if ({res, otag} !== {ve[i], 4'(i + 10)} || lat != 3) begin
        errors++;
        $display("FAIL ovf_unf_vec%0d: got %h lat %0d expected %h", i, res, lat, ve[i]);
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] va[3] = '{32'h80000000, 32'h0000007B, 32'h7F800000};
    logic [31:0] vb[3] = '{32'h80000000, 32'h3F800000, 32'h7F000000};
    logic        vs[3] = '{1'b0, 1'b0, 1'b1};
    logic [34:0] ve[3] = '{{32'h80000000, 3'b000}, {32'h3F800000, 3'b000},
                           {32'h7F000000, 3'b000}};
    logic [34:0] res;
    logic [3:0]  otag;
    int          lat;
    for (int i = 0; i < 3; i++) begin
      apply(va[i], vb[i], vs[i], 4'(i + 12), res, otag, lat);
      checks++;
      if ({res, otag} !== {ve[i], 4'(i + 12)} || lat != 3) begin
        errors++;
        $display("FAIL zero_vec%0d: got %h lat %0d expected %h", i, res, lat, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          cyc = 0, next_tag = 0, exp_tag = 0, done_cyc = -1, extra = 0;
    logic        stalled = 1'b0;
    logic [38:0] snap = '0, cur, want;
    while (exp_tag < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc <= 8);
      in_valid  = (next_tag < 8);
      {a_sign, a_exp, a_mant} = {1'b0, 8'(100 + next_tag), 23'd0};
      {b_sign, b_exp, b_mant} = {1'b0, 8'(100 + next_tag), 23'd0};
      op_sub = 1'b0;
      in_tag = 4'(next_tag);
      #1;
      cur = {c_sign, c_exp, c_mant, flag_ovf, flag_unf, flag_inexact, out_tag};
      if (out_valid && !out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, in_ready);
        end
      end
      if (stalled) begin
        checks++;
        if (cur !== snap || out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_hold: cycle %0d got %h expected %h", cyc, cur, snap);
        end
      end
      if (out_valid && out_ready) begin
        want = {1'b0, 8'(101 + exp_tag), 23'd0, 3'b000, 4'(exp_tag)};
        checks++;
        if (cur !== want) begin
          errors++; $display("FAIL stream_out: cycle %0d got %h expected %h", cyc, cur, want);
        end
        exp_tag++;
        if (exp_tag == 8) done_cyc = cyc;
      end
      stalled = out_valid && !out_ready;
      snap    = cur;
      if (in_valid && in_ready) next_tag++;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (done_cyc != 15) begin
      errors++; $display("FAIL stream_throughput: last result cycle %0d expected 15", done_cyc);
    end
    repeat (3) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL stream_duplicate: got %0d extra results expected 0", extra);
    end
  endtask

  task automatic test_reset_midflight();
    int          stale = 0;
    logic [34:0] res;
    logic [3:0]  otag;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {a_sign, a_exp, a_mant} = 32'h3F800000;
      {b_sign, b_exp, b_mant} = 32'h3F800000;
      op_sub   = 1'b0;
      in_tag   = 4'(9 + i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_tag !== 4'd9) begin
      errors++; $display("FAIL midflight_fill: got valid %b tag %h expected 1 9", out_valid, out_tag);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_async: got valid %b ready %b expected 0 1", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || c_exp !== 8'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL midflight_clear: got valid %b exp %h tag %h expected 0 0 0",
               out_valid, c_exp, out_tag);
    end
    reset_n = 1'b1;
    repeat (6) begin
      if (out_valid) stale++;
      @(negedge clk);
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL midflight_stale: got %0d stale results expected 0", stale);
    end
    apply(32'h3F800000, 32'h3F000000, 1'b0, 4'h3, res, otag, lat);
    checks++;
    if ({res, otag} !== {32'h3FC00000, 3'b000, 4'h3} || lat != 3) begin
      errors++;
      $display("FAIL post_reset_op: got %h tag %h lat %0d expected %h tag 3 lat 3",
               res, otag, lat, {32'h3FC00000, 3'b000});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_basic();
    test_sub();
    test_round();
    test_ovf_unf();
    test_zero();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
